// File: rtl/usb_txn_sequencer_pkg.sv
// Shared definitions for the USB device-side transaction sequencer:
// PID byte values, FSM state encoding and small selection helpers.
package usb_txn_sequencer_pkg;

  // PID bytes as they appear on the wire (PID nibble plus its complement)
  localparam logic [7:0] PID_OUT   = 8'h1E;
  localparam logic [7:0] PID_IN    = 8'h96;
  localparam logic [7:0] PID_SETUP = 8'hD2;
  localparam logic [7:0] PID_SOF   = 8'h5A;
  localparam logic [7:0] PID_DATA0 = 8'h3C;
  localparam logic [7:0] PID_DATA1 = 8'hB4;
  localparam logic [7:0] PID_ACK   = 8'h2D;
  localparam logic [7:0] PID_NAK   = 8'hA5;
  localparam logic [7:0] PID_STALL = 8'hE1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_IN_DECIDE = 3'd2,
    ST_SEND_DATA = 3'd3,
    ST_WAIT_HS   = 3'd4,
    ST_SEND_HS   = 3'd5
  } state_e;

  // Pick one endpoint's bit out of a per-endpoint vector (zero-extended to 16).
  function automatic logic sel_ep(input logic [15:0] vec, input logic [3:0] ep);
    return vec[ep];
  endfunction

  // Data PID matching a DATA0/DATA1 toggle bit.
  function automatic logic [7:0] data_pid(input logic tog);
    return tog ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usb_txn_sequencer_ep_toggle.sv
// Per-endpoint DATA0/DATA1 toggle storage. One rx and one tx toggle per
// endpoint; the addressed endpoint can be forced to DATA1 (after SETUP)
// or have either toggle flipped. Read-out is for the addressed endpoint.
module usb_ep_toggle
  import usb_txn_sequencer_pkg::*;
#(
  parameter int NUM_EP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ep,
  input  logic       set_both,
  input  logic       flip_rx,
  input  logic       flip_tx,
  output logic       rx_tog_cur,
  output logic       tx_tog_cur
);

  logic [NUM_EP-1:0] rx_tog;
  logic [NUM_EP-1:0] tx_tog;

  // Toggle update for the addressed endpoint; everything clears on reset
  // NOTE: these toggle bits are ordinary flops, so resetting the whole array is
  // cheap and required -- a host always starts every endpoint at DATA0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_tog <= '0;
      tx_tog <= '0;
    end else begin
      for (int i = 0; i < NUM_EP; i++) begin
        if (ep == 4'(i)) begin
          if (set_both) begin
            rx_tog[i] <= 1'b1;
            tx_tog[i] <= 1'b1;
          end else begin
            if (flip_rx) rx_tog[i] <= ~rx_tog[i];
            if (flip_tx) tx_tog[i] <= ~tx_tog[i];
          end
        end
      end
    end
  end

  assign rx_tog_cur = sel_ep(16'(rx_tog), ep);
  assign tx_tog_cur = sel_ep(16'(tx_tog), ep);

endmodule

// File: rtl/usb_txn_sequencer.sv
// Device-side USB transaction sequencer. Qualifies decoded tokens, walks
// the token -> data -> handshake phases, tracks data toggles per endpoint
// and commands the packet transmitter and endpoint buffers.
module usb_txn_sequencer
  import usb_txn_sequencer_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h7F,
  parameter int         NUM_EP   = 4,
  parameter int         TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              token_valid,
  input  logic [23:0]       token,
  input  logic              token_err,
  input  logic              rx_valid,
  input  logic [7:0]        rx_pid,
  input  logic              rx_err,
  input  logic              hs_valid,
  input  logic [7:0]        hs_pid,
  input  logic [NUM_EP-1:0] ep_stall,
  input  logic [NUM_EP-1:0] ep_ready,
  input  logic              tx_ready,
  output logic              hs_tx_valid,
  output logic              data_tx_valid,
  output logic [7:0]        tx_pid,
  output logic [3:0]        cur_ep,
  output logic              rx_commit,
  output logic              rx_setup,
  output logic              tx_done,
  output logic              timeout_err,
  output logic              busy
);

  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);
  localparam logic [4:0]    EP_LIMIT = 5'(NUM_EP);

  // Token fields; the CRC5 has already been checked upstream (token_err)
  logic [7:0] tok_pid;
  logic [6:0] tok_addr;
  logic [3:0] tok_ep;
  logic       unused_crc;
  assign tok_pid    = token[23:16];
  assign tok_addr   = token[15:9];
  assign tok_ep     = token[8:5];
  assign unused_crc = &{1'b0, token[4:0]};

  state_e        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [3:0]    ep_d;
  logic          is_setup, is_setup_d;
  logic [7:0]    hs_pid_q, hs_pid_d;
  logic          commit_d, setup_d, done_d, tout_d;
  logic          set_both, flip_rx, flip_tx;
  logic          rx_tog_cur, tx_tog_cur;
  logic          stall_cur, ready_cur, tok_ok, timer_exp;

  assign stall_cur = sel_ep(16'(ep_stall), cur_ep);
  assign ready_cur = sel_ep(16'(ep_ready), cur_ep);
  assign tok_ok    = token_valid && !token_err && (tok_addr == DEV_ADDR)
                     && ({1'b0, tok_ep} < EP_LIMIT);
  assign timer_exp = (timer == TMAX);

  usb_ep_toggle #(.NUM_EP(NUM_EP)) u_toggle (
    .clk        (clk),
    .rst        (rst),
    .ep         (cur_ep),
    .set_both   (set_both),
    .flip_rx    (flip_rx),
    .flip_tx    (flip_tx),
    .rx_tog_cur (rx_tog_cur),
    .tx_tog_cur (tx_tog_cur)
  );

  // State, phase timer, transaction context and the one-cycle event pulses
  // NOTE: every flop here uses <= so all of them update from the same pre-edge
  // values; a blocking = would let later lines see half-updated state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      cur_ep      <= '0;
      is_setup    <= 1'b0;
      hs_pid_q    <= 8'h00;
      rx_commit   <= 1'b0;
      rx_setup    <= 1'b0;
      tx_done     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      cur_ep      <= ep_d;
      is_setup    <= is_setup_d;
      hs_pid_q    <= hs_pid_d;
      rx_commit   <= commit_d;
      rx_setup    <= setup_d;
      tx_done     <= done_d;
      timeout_err <= tout_d;
    end
  end

  // Next-state logic: phase sequencing, handshake choice, toggle/commit events
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned -- that is what keeps this block from inferring latches.
  always_comb begin
    state_d    = state;
    timer_d    = timer;
    ep_d       = cur_ep;
    is_setup_d = is_setup;
    hs_pid_d   = hs_pid_q;
    commit_d   = 1'b0;
    setup_d    = 1'b0;
    done_d     = 1'b0;
    tout_d     = 1'b0;
    set_both   = 1'b0;
    flip_rx    = 1'b0;
    flip_tx    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        timer_d = '0;
        if (tok_ok) begin
          unique case (tok_pid)
            PID_SETUP: begin
              state_d    = ST_WAIT_DATA;
              ep_d       = tok_ep;
              is_setup_d = 1'b1;
            end
            PID_OUT: begin
              state_d    = ST_WAIT_DATA;
              ep_d       = tok_ep;
              is_setup_d = 1'b0;
            end
            PID_IN: begin
              state_d = ST_IN_DECIDE;
              ep_d    = tok_ep;
            end
            PID_SOF: ;  // frame marker, nothing to sequence
            default: ;
          endcase
        end
      end

      ST_WAIT_DATA: begin
        if (rx_valid) begin
          // A packet arriving on the expiry cycle still counts
          state_d = ST_IDLE;
          if (!rx_err && (rx_pid == PID_DATA0 || rx_pid == PID_DATA1)) begin
            if (is_setup) begin
              // SETUP must be DATA0 and is always accepted
              if (rx_pid == PID_DATA0) begin
                state_d  = ST_SEND_HS;
                hs_pid_d = PID_ACK;
                commit_d = 1'b1;
                setup_d  = 1'b1;
                set_both = 1'b1;
              end
            end else begin
              state_d = ST_SEND_HS;
              if (stall_cur) begin
                hs_pid_d = PID_STALL;
              end else if (!ready_cur) begin
                hs_pid_d = PID_NAK;
              end else begin
                hs_pid_d = PID_ACK;
                // A wrong toggle is a host retry of data we already stored
                if (rx_pid == data_pid(rx_tog_cur)) begin
                  commit_d = 1'b1;
                  flip_rx  = 1'b1;
                end
              end
            end
          end
        end else if (timer_exp) begin
          state_d = ST_IDLE;
          tout_d  = 1'b1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end

      ST_IN_DECIDE: begin
        if (stall_cur) begin
          state_d  = ST_SEND_HS;
          hs_pid_d = PID_STALL;
        end else if (!ready_cur) begin
          state_d  = ST_SEND_HS;
          hs_pid_d = PID_NAK;
        end else begin
          state_d = ST_SEND_DATA;
        end
      end

      ST_SEND_DATA: begin
        timer_d = '0;
        if (tx_ready) state_d = ST_WAIT_HS;
      end

      ST_WAIT_HS: begin
        if (hs_valid) begin
          state_d = ST_IDLE;
          if (hs_pid == PID_ACK) begin
            done_d  = 1'b1;
            flip_tx = 1'b1;
          end
        end else if (timer_exp) begin
          state_d = ST_IDLE;
          tout_d  = 1'b1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end

      ST_SEND_HS: begin
        if (tx_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Transmitter requests and status decoded from the current state
  always_comb begin
    hs_tx_valid   = 1'b0;
    data_tx_valid = 1'b0;
    tx_pid        = 8'h00;
    busy          = (state != ST_IDLE);
    if (state == ST_SEND_HS) begin
      hs_tx_valid = 1'b1;
      tx_pid      = hs_pid_q;
    end else if (state == ST_SEND_DATA) begin
      data_tx_valid = 1'b1;
      tx_pid        = data_pid(tx_tog_cur);
    end
  end

endmodule

// File: tb/tb_usb_txn_sequencer.sv
// Directed bench for usb_txn_sequencer: a table of one-cycle vectors with
// hand-computed expected outputs, plus hand-written timeout/reset sequences.
module tb_usb_txn_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        token_valid;
  logic [23:0] token;
  logic        token_err;
  logic        rx_valid;
  logic [7:0]  rx_pid;
  logic        rx_err;
  logic        hs_valid;
  logic [7:0]  hs_pid;
  logic [3:0]  ep_stall;
  logic [3:0]  ep_ready;
  logic        tx_ready;
  logic        hs_tx_valid, data_tx_valid;
  logic [7:0]  tx_pid;
  logic [3:0]  cur_ep;
  logic        rx_commit, rx_setup, tx_done, timeout_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  usb_txn_sequencer #(.DEV_ADDR(7'h7F), .NUM_EP(4), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .token_valid   (token_valid),
    .token         (token),
    .token_err     (token_err),
    .rx_valid      (rx_valid),
    .rx_pid        (rx_pid),
    .rx_err        (rx_err),
    .hs_valid      (hs_valid),
    .hs_pid        (hs_pid),
    .ep_stall      (ep_stall),
    .ep_ready      (ep_ready),
    .tx_ready      (tx_ready),
    .hs_tx_valid   (hs_tx_valid),
    .data_tx_valid (data_tx_valid),
    .tx_pid        (tx_pid),
    .cur_ep        (cur_ep),
    .rx_commit     (rx_commit),
    .rx_setup      (rx_setup),
    .tx_done       (tx_done),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tv;
    logic [23:0] tk;
    logic        terr;
    logic        rv;
    logic [7:0]  rpid;
    logic        rerr;
    logic        hv;
    logic [7:0]  hpid;
    logic [3:0]  stall;
    logic [3:0]  ready;
    logic        txr;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Expected output word: {busy, hs_tx_valid, data_tx_valid, tx_pid, rx_commit, rx_setup, tx_done, timeout_err, cur_ep}
  function automatic logic [18:0] e(input logic b, hs, dv, input logic [7:0] pid,
                                    input logic cm, su, dn, to, input logic [3:0] ep);
    return {b, hs, dv, pid, cm, su, dn, to, ep};
  endfunction
  function automatic logic [18:0] z(input logic [3:0] ep);
    return e(0, 0, 0, 8'h00, 0, 0, 0, 0, ep);
  endfunction
  function automatic logic [18:0] bz(input logic [3:0] ep);
    return e(1, 0, 0, 8'h00, 0, 0, 0, 0, ep);
  endfunction

  function automatic logic [18:0] obs();
    return {busy, hs_tx_valid, data_tx_valid, tx_pid, rx_commit, rx_setup, tx_done, timeout_err, cur_ep};
  endfunction

  function automatic vec_t r_idle(input logic txr, input logic [18:0] x);
    vec_t v;
    v.tv = 0; v.tk = '0; v.terr = 0; v.rv = 0; v.rpid = '0; v.rerr = 0;
    v.hv = 0; v.hpid = '0; v.stall = 4'h0; v.ready = 4'hF; v.txr = txr; v.exp = x;
    return v;
  endfunction
  function automatic vec_t r_tok(input logic [7:0] pid, input logic [6:0] addr,
                                 input logic [3:0] ep, input logic terr, input logic [18:0] x);
    vec_t v = r_idle(1'b1, x);
    v.tv = 1; v.tk = {pid, addr, ep, 5'h00}; v.terr = terr;
    return v;
  endfunction
  function automatic vec_t r_rx(input logic [7:0] pid, input logic err, input logic [3:0] stall,
                                input logic [3:0] ready, input logic [18:0] x);
    vec_t v = r_idle(1'b1, x);
    v.rv = 1; v.rpid = pid; v.rerr = err; v.stall = stall; v.ready = ready;
    return v;
  endfunction
  function automatic vec_t r_hs(input logic [7:0] pid, input logic [18:0] x);
    vec_t v = r_idle(1'b1, x);
    v.hv = 1; v.hpid = pid;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    token_valid = 0; token = '0; token_err = 0;
    rx_valid = 0; rx_pid = '0; rx_err = 0;
    hs_valid = 0; hs_pid = '0;
    ep_stall = 4'h0; ep_ready = 4'hF; tx_ready = 1;
  endtask

  task automatic send_tok(input logic [7:0] pid, input logic [3:0] ep);
    set_idle();
    token_valid = 1; token = {pid, 7'h7F, ep, 5'h00};
    step();
    set_idle();
  endtask

  // n_busy more cycles with busy high and no pulse, then expiry pulse, then quiet
  task automatic expect_timeout(input string tag, input int n_busy);
    for (int i = 0; i < n_busy; i++) begin
      step();
      check($sformatf("%s_wait%0d", tag, i), {busy, timeout_err}, 2'b10);
    end
    step();
    check({tag, "_expire"}, {busy, timeout_err}, 2'b01);
    step();
    check({tag, "_after"}, {busy, timeout_err}, 2'b00);
  endtask

  initial begin
    // SETUP ep0 with DATA0: ACK plus commit/setup pulses, toggles to 1
    vecs.push_back(r_tok(8'hD2, 7'h7F, 4'd0, 0, bz(0)));
    vecs.push_back(r_rx(8'h3C, 0, 4'h0, 4'hF, e(1, 1, 0, 8'h2D, 1, 1, 0, 0, 0)));
    vecs.push_back(r_idle(1, z(0)));
    // Tokens that must be ignored: wrong addr, endp out of range, CRC error, SOF, non-token PID
    vecs.push_back(r_tok(8'h1E, 7'h05, 4'd0, 0, z(0)));
    vecs.push_back(r_tok(8'h1E, 7'h7F, 4'd4, 0, z(0)));
    vecs.push_back(r_tok(8'h1E, 7'h7F, 4'd1, 1, z(0)));
    vecs.push_back(r_tok(8'h5A, 7'h7F, 4'd1, 0, z(0)));
    vecs.push_back(r_tok(8'h2D, 7'h7F, 4'd1, 0, z(0)));
    // IN ep0 after SETUP sends DATA1; host NAK leaves the transaction without tx_done
    vecs.push_back(r_tok(8'h96, 7'h7F, 4'd0, 0, bz(0)));
    vecs.push_back(r_idle(1, e(1, 0, 1, 8'hB4, 0, 0, 0, 0, 0)));
    vecs.push_back(r_idle(1, bz(0)));
    vecs.push_back(r_hs(8'hA5, z(0)));
    // SETUP followed by DATA1 is dropped silently
    vecs.push_back(r_tok(8'hD2, 7'h7F, 4'd0, 0, bz(0)));
    vecs.push_back(r_rx(8'hB4, 0, 4'h0, 4'hF, z(0)));
    // OUT ep3: CRC16 error, then a non-data PID, both silent
    vecs.push_back(r_tok(8'h1E, 7'h7F, 4'd3, 0, bz(3)));
    vecs.push_back(r_rx(8'h3C, 1, 4'h0, 4'hF, z(3)));
    vecs.push_back(r_tok(8'h1E, 7'h7F, 4'd3, 0, bz(3)));
    vecs.push_back(r_rx(8'h2D, 0, 4'h0, 4'hF, z(3)));
    // OUT ep1 DATA0 twice: both ACKed, only the first commits; then DATA1 commits
    vecs.push_back(r_tok(8'h1E, 7'h7F, 4'd1, 0, bz(1)));
    vecs.push_back(r_rx(8'h3C, 0, 4'h0, 4'hF, e(1, 1, 0, 8'h2D, 1, 0, 0, 0, 1)));
    vecs.push_back(r_idle(1, z(1)));
    vecs.push_back(r_tok(8'h1E, 7'h7F, 4'd1, 0, bz(1)));
    vecs.push_back(r_rx(8'h3C, 0, 4'h0, 4'hF, e(1, 1, 0, 8'h2D, 0, 0, 0, 0, 1)));
    vecs.push_back(r_idle(1, z(1)));
    vecs.push_back(r_tok(8'h1E, 7'h7F, 4'd1, 0, bz(1)));
    vecs.push_back(r_rx(8'hB4, 0, 4'h0, 4'hF, e(1, 1, 0, 8'h2D, 1, 0, 0, 0, 1)));
    vecs.push_back(r_idle(1, z(1)));
    // OUT ep0 after SETUP expects DATA1
    vecs.push_back(r_tok(8'h1E, 7'h7F, 4'd0, 0, bz(0)));
    vecs.push_back(r_rx(8'hB4, 0, 4'h0, 4'hF, e(1, 1, 0, 8'h2D, 1, 0, 0, 0, 0)));
    vecs.push_back(r_idle(1, z(0)));
    // OUT ep2 not ready -> NAK; stalled -> STALL held while tx_ready low
    vecs.push_back(r_tok(8'h1E, 7'h7F, 4'd2, 0, bz(2)));
    vecs.push_back(r_rx(8'h3C, 0, 4'h0, 4'b1011, e(1, 1, 0, 8'hA5, 0, 0, 0, 0, 2)));
    vecs.push_back(r_idle(1, z(2)));
    vecs.push_back(r_tok(8'h1E, 7'h7F, 4'd2, 0, bz(2)));
    vecs.push_back(r_rx(8'h3C, 0, 4'b0100, 4'hF, e(1, 1, 0, 8'hE1, 0, 0, 0, 0, 2)));
    vecs.push_back(r_idle(0, e(1, 1, 0, 8'hE1, 0, 0, 0, 0, 2)));
    vecs.push_back(r_idle(1, z(2)));
    // IN ep1: DATA0, host ACK -> tx_done; next IN sends DATA1 and waits for handshake
    vecs.push_back(r_tok(8'h96, 7'h7F, 4'd1, 0, bz(1)));
    vecs.push_back(r_idle(1, e(1, 0, 1, 8'h3C, 0, 0, 0, 0, 1)));
    vecs.push_back(r_idle(1, bz(1)));
    vecs.push_back(r_hs(8'h2D, e(0, 0, 0, 8'h00, 0, 0, 1, 0, 1)));
    vecs.push_back(r_tok(8'h96, 7'h7F, 4'd1, 0, bz(1)));
    vecs.push_back(r_idle(1, e(1, 0, 1, 8'hB4, 0, 0, 0, 0, 1)));
    vecs.push_back(r_idle(1, bz(1)));

    // Reset state
    set_idle();
    rst = 0;
    #12;
    check("reset_outputs", 32'(obs()), 32'(z(0)));
    @(negedge clk);
    rst = 1;
    step();
    check("reset_idle", 32'(obs()), 32'(z(0)));

    // Table-driven vectors
    foreach (vecs[i]) begin
      token_valid = vecs[i].tv;  token    = vecs[i].tk;    token_err = vecs[i].terr;
      rx_valid    = vecs[i].rv;  rx_pid   = vecs[i].rpid;  rx_err    = vecs[i].rerr;
      hs_valid    = vecs[i].hv;  hs_pid   = vecs[i].hpid;
      ep_stall    = vecs[i].stall; ep_ready = vecs[i].ready; tx_ready = vecs[i].txr;
      step();
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end
    set_idle();

    // DUT sits in WAIT_HS (timer 0) for ep1: no host ACK -> timeout after 16 cycles
    expect_timeout("in_hs_timeout", 15);

    // Toggle must not have flipped: retry still sends DATA1
    send_tok(8'h96, 4'd1);
    step();
    check("in_retry_pid", {data_tx_valid, tx_pid}, {1'b1, 8'hB4});
    step();
    hs_valid = 1; hs_pid = 8'h2D;
    step();
    check("in_retry_done", {busy, tx_done}, 2'b01);
    set_idle();

    // OUT ep3 with no data: token during WAIT_DATA ignored, then timeout
    send_tok(8'h1E, 4'd3);
    token_valid = 1; token = {8'h96, 7'h7F, 4'd1, 5'h00};
    step();
    set_idle();
    check("busy_token_ignored", {busy, data_tx_valid, cur_ep}, {1'b1, 1'b0, 4'd3});
    expect_timeout("out_data_timeout", 14);

    // Reset mid SEND_DATA with tx_ready low
    set_idle();
    tx_ready = 0;
    token_valid = 1; token = {8'h96, 7'h7F, 4'd3, 5'h00};
    step();
    token_valid = 0;
    step();
    check("send_data_held0", {data_tx_valid, tx_pid}, {1'b1, 8'h3C});
    step();
    check("send_data_held1", {data_tx_valid, tx_pid, cur_ep}, {1'b1, 8'h3C, 4'd3});
    #2;
    rst = 0;
    #1;
    check("midtxn_reset_outputs", 32'(obs()), 32'(z(0)));
    @(negedge clk);
    rst = 1;
    set_idle();
    step();

    // Toggles cleared: IN ep0 back to DATA0, OUT ep1 DATA0 commits again
    send_tok(8'h96, 4'd0);
    step();
    check("post_reset_tx_tog", {data_tx_valid, tx_pid}, {1'b1, 8'h3C});
    step();
    hs_valid = 1; hs_pid = 8'hA5;
    step();
    set_idle();
    send_tok(8'h1E, 4'd1);
    rx_valid = 1; rx_pid = 8'h3C;
    step();
    set_idle();
    check("post_reset_rx_tog", {hs_tx_valid, tx_pid, rx_commit}, {1'b1, 8'h2D, 1'b1});
    step();
    check("final_idle", {busy, hs_tx_valid}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
